// File: rtl/ext_pipe.sv
// Buffered immediate / load-data extension unit feeding a DEPTH-entry result FIFO.
// Optional macro EXT_ERR_EN: store a misaligned-halfword flag with each entry.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int AL_W  = $clog2(DATA_W / 8),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        eop,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] data,
  input  logic [AL_W-1:0]   addr_lo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] immSext;
  logic [AL_W+2:0]   byteOff;
  logic [AL_W+2:0]   halfOff;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [DATA_W-1:0] res_d;

  logic [DATA_W-1:0] dataMem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push;
  logic              pop;

  assign immSext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  // Halfword offset is the byte offset rounded down to a 16-bit boundary.
  assign byteOff = {addr_lo, 3'b000};
  assign halfOff = (byteOff >> 4) << 4;
  assign byteSel = data[byteOff +: 8];
  assign halfSel = data[halfOff +: 16];

  always_comb begin
    res_d = '0;
    case (eop)
      3'd0:    res_d = immSext;
      3'd1:    res_d = {{(DATA_W-IMM_W){1'b0}}, imm};
      3'd2:    res_d = {imm, {(DATA_W-IMM_W){1'b0}}};
      3'd3:    res_d = {immSext[DATA_W-3:0], 2'b00};
      3'd4:    res_d = {{(DATA_W-8){byteSel[7]}}, byteSel};
      3'd5:    res_d = {{(DATA_W-8){1'b0}}, byteSel};
      3'd6:    res_d = {{(DATA_W-16){halfSel[15]}}, halfSel};
      default: res_d = {{(DATA_W-16){1'b0}}, halfSel};
    endcase
  end

  assign in_ready  = (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = level_q;
  assign out_data  = out_valid ? dataMem_q[rdPtr_q] : '0;

  always_comb begin
    wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + LVL_W'(1);
    else if (pop && !push)
      level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; emptiness is tracked by level and masks the output.
  always_ff @(posedge clk) begin
    if (push)
      dataMem_q[wrPtr_q] <= res_d;
  end

`ifdef EXT_ERR_EN
  logic errMem_q [DEPTH];
  logic err_d;

  assign err_d   = (eop[2:1] == 2'b11) && addr_lo[0];
  assign out_err = out_valid && errMem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (push)
      errMem_q[wrPtr_q] <= err_d;
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: queue-based reference model compared every cycle,
// plus directed vectors with hand-computed literal results.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  eop;
  logic [15:0] imm;
  logic [31:0] data;
  logic [1:0]  addr_lo;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [1:0]  level;

  int checks = 0;
  int errors = 0;
  bit modelLive = 1'b0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } entry_t;

  entry_t modelQ[$];

  ext_pipe #(.IMM_W(16), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .eop(eop), .imm(imm), .data(data), .addr_lo(addr_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .level(level)
  );

  always #5 clk = ~clk;

  function automatic entry_t modelExt(input logic [2:0] e, input logic [15:0] im,
                                      input logic [31:0] d, input logic [1:0] a);
    entry_t r;
    int signed sImm;
    int signed sByte;
    int signed sHalf;
    logic [7:0]  b;
    logic [15:0] h;
    sImm  = $signed(im);
    b     = 8'(d >> (8 * a));
    h     = 16'(d >> (16 * (a / 2)));
    sByte = $signed(b);
    sHalf = $signed(h);
    case (e)
      3'd0:    r.data = sImm;
      3'd1:    r.data = {16'h0, im};
      3'd2:    r.data = {im, 16'h0};
      3'd3:    r.data = sImm * 4;
      3'd4:    r.data = sByte;
      3'd5:    r.data = {24'h0, b};
      3'd6:    r.data = sHalf;
      default: r.data = {16'h0, h};
    endcase
`ifdef EXT_ERR_EN
    r.err = (e >= 3'd6) && (a % 2 == 1);
`else
    r.err = 1'b0;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    entry_t nxt;
    bit doPop;
    bit doPush;
    if (reset) begin
      modelQ.delete();
      modelLive = 1'b1;
    end else if (modelLive) begin
      doPop  = (modelQ.size() > 0) && out_ready;
      doPush = in_valid && (modelQ.size() < 2);
      nxt    = modelExt(eop, imm, data, addr_lo);
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(nxt);
    end
  end

  task automatic checkVal(input string name, input logic [32:0] actual, input logic [32:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (modelLive) begin
      checkVal("model_level", 33'(level), 33'(modelQ.size()));
      checkVal("model_in_ready", 33'(in_ready), 33'(modelQ.size() < 2));
      checkVal("model_out_valid", 33'(out_valid), 33'(modelQ.size() > 0));
      checkVal("model_out_data", 33'(out_data), (modelQ.size() > 0) ? 33'(modelQ[0].data) : 33'(0));
      checkVal("model_out_err", 33'(out_err), (modelQ.size() > 0) ? 33'(modelQ[0].err) : 33'(0));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] expData, input logic expErr);
    checkVal({name, "_valid"}, 33'(out_valid), 33'(1));
    checkVal({name, "_data"}, 33'(out_data), 33'(expData));
    checkVal({name, "_err"}, 33'(out_err), 33'(expErr));
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] e, input logic [15:0] im,
                               input logic [31:0] d, input logic [1:0] a,
                               input logic [31:0] expData, input logic expErr);
    in_valid = 1'b1; eop = e; imm = im; data = d; addr_lo = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput(name, expData, expErr);
  endtask

  task automatic offer(input logic [2:0] e, input logic [15:0] im);
    in_valid = 1'b1; eop = e; imm = im; data = 32'h0; addr_lo = 2'd0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int i;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (i = 0; i < 10 && level != 2'd0; i++) @(negedge clk);
    checkVal(name, 33'(level), 33'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic expErrLh1;
`ifdef EXT_ERR_EN
    expErrLh1 = 1'b1;
`else
    expErrLh1 = 1'b0;
`endif
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    eop = 3'd0; imm = 16'h0; data = 32'h0; addr_lo = 2'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkVal("reset_level", 33'(level), 33'(0));
    checkVal("reset_in_ready", 33'(in_ready), 33'(1));
    checkVal("reset_out_valid", 33'(out_valid), 33'(0));

    // Immediate modes, one result per cycle with the consumer always ready.
    out_ready = 1'b1;
    applyStimulus("imm_sext", 3'd0, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0);
    applyStimulus("imm_zext", 3'd1, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0);
    applyStimulus("imm_upper", 3'd2, 16'h8001, 32'h0, 2'd0, 32'h80010000, 1'b0);
    applyStimulus("imm_branch", 3'd3, 16'h8001, 32'h0, 2'd0, 32'hFFFE0004, 1'b0);

    applyStimulus("lb_a0", 3'd4, 16'h0, 32'h80FF7F01, 2'd0, 32'h00000001, 1'b0);
    applyStimulus("lb_a1", 3'd4, 16'h0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0);
    applyStimulus("lb_a2", 3'd4, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0);
    applyStimulus("lb_a3", 3'd4, 16'h0, 32'h80FF7F01, 2'd3, 32'hFFFFFF80, 1'b0);
    applyStimulus("lbu_a2", 3'd5, 16'h0, 32'h80FF7F01, 2'd2, 32'h000000FF, 1'b0);
    applyStimulus("lh_a2", 3'd6, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0);
    applyStimulus("lhu_a0", 3'd7, 16'h0, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0);
    applyStimulus("lh_a1", 3'd6, 16'h0, 32'h80FF7F01, 2'd1, 32'h00007F01, expErrLh1);
    applyStimulus("lhu_a3", 3'd7, 16'h0, 32'h80FF7F01, 2'd3, 32'h000080FF, expErrLh1);
    drain("drain_after_ops");

    // Fill to full with the consumer stalled; a third offer must be refused.
    @(negedge clk);
    out_ready = 1'b0;
    offer(3'd0, 16'h0005);
    offer(3'd1, 16'hFFFF);
    in_valid = 1'b1; eop = 3'd2; imm = 16'h1234;
    @(negedge clk);
    checkVal("full_in_ready", 33'(in_ready), 33'(0));
    checkVal("full_level", 33'(level), 33'(2));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("full_hold_level", 33'(level), 33'(2));
    checkVal("full_head", 33'(out_data), 33'(32'h00000005));
    out_ready = 1'b1;
    @(negedge clk);
    checkVal("full_second", 33'(out_data), 33'(32'h0000FFFF));
    checkVal("full_second_level", 33'(level), 33'(1));
    drain("drain_after_full");

    // Simultaneous push and pop at level one.
    @(negedge clk);
    out_ready = 1'b0;
    offer(3'd1, 16'h00AA);
    in_valid = 1'b1; eop = 3'd1; imm = 16'h00BB; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checkVal("pushpop_level", 33'(level), 33'(1));
    checkVal("pushpop_head", 33'(out_data), 33'(32'h000000BB));
    drain("drain_after_pushpop");

    // Reset while full discards everything.
    @(negedge clk);
    out_ready = 1'b0;
    offer(3'd0, 16'h7777);
    offer(3'd0, 16'h8888);
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("prereset_level", 33'(level), 33'(2));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkVal("midreset_level", 33'(level), 33'(0));
    checkVal("midreset_out_valid", 33'(out_valid), 33'(0));
    checkVal("midreset_out_data", 33'(out_data), 33'(0));
    checkVal("midreset_in_ready", 33'(in_ready), 33'(1));

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
